// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: 2-flop synchroniser, tick-gated stability filter, edge strobes.
// Optional long-press detect is built only when MULTI_DEBOUNCER_LONG_PRESS_EN is defined.
module multi_debouncer #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned THRESH      = 500000,
  parameter int unsigned CNT_W       = 20,
  parameter logic        RESET_LEVEL = 1'b1,
  parameter int unsigned LONG_THRESH = 50000000,
  parameter int unsigned LONG_W      = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] db_rise,
  output logic [CHANNELS-1:0] db_fall,
  output logic [CHANNELS-1:0] long_press
);

  localparam logic [CHANNELS-1:0] IDLE     = {CHANNELS{RESET_LEVEL}};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(THRESH - 1);

  if ((64'(1) << CNT_W) <= 64'(THRESH)) begin : gBadCntW
    $error("CNT_W too narrow for THRESH");
  end
  if ((64'(1) << LONG_W) <= 64'(LONG_THRESH)) begin : gBadLongW
    $error("LONG_W too narrow for LONG_THRESH");
  end

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= IDLE;
      s2 <= IDLE;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Any sample agreeing with the current level restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= IDLE;
      db_rise  <= '0;
      db_fall  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        db_rise[i] <= 1'b0;
        db_fall[i] <= 1'b0;
        if (s2[i] == db_level[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            db_level[i] <= s2[i];
            cnt[i]      <= '0;
            db_rise[i]  <= s2[i];
            db_fall[i]  <= ~s2[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_THRESH - 1);

  logic [LONG_W-1:0]   longCnt [CHANNELS];
  logic [CHANNELS-1:0] longFired;

  // Counter saturates at LONG_LAST; longFired limits the strobe to one per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_press <= '0;
      longFired  <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) longCnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        long_press[i] <= 1'b0;
        if (db_level[i] == RESET_LEVEL) begin
          longCnt[i]   <= '0;
          longFired[i] <= 1'b0;
        end else if (longCnt[i] != LONG_LAST) begin
          longCnt[i] <= longCnt[i] + 1'b1;
        end else if (!longFired[i]) begin
          long_press[i] <= 1'b1;
          longFired[i]  <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with a per-cycle behavioural model and literal pins.
module tb_multi_debouncer;

  localparam int TH = 4;
  localparam int LT = 10;
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] raw_in;
  logic [3:0] db_level, db_rise, db_fall, long_press;

  int tests = 0;
  int fails = 0;

  multi_debouncer #(
    .CHANNELS(4), .THRESH(TH), .CNT_W(3), .RESET_LEVEL(1'b1),
    .LONG_THRESH(LT), .LONG_W(4)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .raw_in(raw_in),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw delayed two samples; level flips after TH consecutive ticked disagreeing samples.
  logic [3:0] m1, m2, mLevel, mRise, mFall, mLong;
  int mRun [4];
  int mHeld [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 = 4'hF; m2 = 4'hF; mLevel = 4'hF;
      mRise = '0; mFall = '0; mLong = '0;
      for (int c = 0; c < 4; c++) begin mRun[c] = 0; mHeld[c] = 0; end
    end else begin
      for (int c = 0; c < 4; c++) begin
        mRise[c] = 1'b0; mFall[c] = 1'b0; mLong[c] = 1'b0;
        if (mLevel[c] != 1'b1) begin
          mHeld[c]++;
          mLong[c] = (mHeld[c] == LT);
        end else begin
          mHeld[c] = 0;
        end
        if (m2[c] == mLevel[c]) mRun[c] = 0;
        else if (tick) begin
          mRun[c]++;
          if (mRun[c] == TH) begin
            mLevel[c] = m2[c];
            mRise[c]  = m2[c];
            mFall[c]  = ~m2[c];
            mRun[c]   = 0;
          end
        end
      end
      m2 = m1;
      m1 = raw_in;
    end
  end

  int fallCnt [4];
  int longCnt [4];
  int cyc = 0;
  int lastFallCyc0 = 0;
  int lastLongCyc0 = 0;

  initial for (int c = 0; c < 4; c++) begin fallCnt[c] = 0; longCnt[c] = 0; end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("level", 32'(db_level), 32'(mLevel));
      check("rise", 32'(db_rise), 32'(mRise));
      check("fall", 32'(db_fall), 32'(mFall));
      check("long", 32'(long_press), LONG_EN ? 32'(mLong) : 32'd0);
      for (int c = 0; c < 4; c++) begin
        if (db_fall[c]) fallCnt[c]++;
        if (long_press[c]) longCnt[c]++;
      end
      if (db_fall[0]) lastFallCyc0 = cyc;
      if (long_press[0]) lastLongCyc0 = cyc;
    end
  end

  bit preMode = 1'b0;
  int phase = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (preMode) begin
        phase = (phase + 1) % 5;
        tick = (phase == 0);
      end else begin
        tick = 1'b1;
      end
    end
  endtask

  int snap;

  initial begin
    rst = 1'b1; raw_in = 4'hF; tick = 1'b1;
    step(3);
    rst = 1'b0;
    step(4);
    check("idle_level", 32'(db_level), 32'hF);
    check("idle_pulses", 32'({db_rise, db_fall}), 32'h0);

    // Reset mid-qualification
    raw_in = 4'h0;
    step(3);
    @(posedge clk); #2; rst = 1'b1; #1;
    check("rst_level", 32'(db_level), 32'hF);
    check("rst_pulses", 32'({db_rise, db_fall}), 32'h0);
    step(1);
    rst = 1'b0;
    step(5);
    check("rel_e5_level", 32'(db_level), 32'hF);
    check("rel_e5_fall", 32'(db_fall), 32'h0);
    step(1);
    check("rel_e6_level", 32'(db_level), 32'h0);
    check("rel_e6_fall", 32'(db_fall), 32'hF);
    step(1);
    check("rel_e7_fall", 32'(db_fall), 32'h0);
    raw_in = 4'hF;
    step(10);

    // Bounce rejection on channel 1
    snap = fallCnt[1];
    raw_in = 4'b1101; step(3);
    raw_in = 4'hF;    step(1);
    raw_in = 4'b1101; step(3);
    raw_in = 4'hF;    step(8);
    check("bounce_nofall", 32'(fallCnt[1] - snap), 32'd0);
    check("bounce_level", 32'(db_level[1]), 32'd1);
    raw_in = 4'b1101; step(8);
    check("hold_onefall", 32'(fallCnt[1] - snap), 32'd1);
    check("hold_level", 32'(db_level[1]), 32'd0);
    raw_in = 4'hF; step(10);

    // Prescaled sampling on channel 2 with a blip between ticks
    snap = fallCnt[2];
    preMode = 1'b1; phase = 0;
    raw_in = 4'b1011; step(12);
    raw_in = 4'hF;    step(1);
    raw_in = 4'b1011; step(40);
    check("pre_onefall", 32'(fallCnt[2] - snap), 32'd1);
    check("pre_level", 32'(db_level[2]), 32'd0);
    preMode = 1'b0;
    raw_in = 4'hF; step(10);

    // Simultaneous flips on channels 3 and 2
    raw_in = 4'b0011;
    step(5);
    check("sim_e5_fall", 32'(db_fall), 32'h0);
    step(1);
    check("sim_fall", 32'(db_fall), 32'hC);
    check("sim_level", 32'(db_level), 32'h3);
    step(4);
    raw_in = 4'hF;
    step(6);
    check("sim_rise", 32'(db_rise), 32'hC);
    step(4);

    // Long press on channel 0, twice
    snap = longCnt[0];
    raw_in = 4'b1110; step(30);
    check("long_first", 32'(longCnt[0] - snap), LONG_EN ? 32'd1 : 32'd0);
    raw_in = 4'hF; step(10);
    raw_in = 4'b1110; step(30);
    check("long_second", 32'(longCnt[0] - snap), LONG_EN ? 32'd2 : 32'd0);
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
    check("long_delay", 32'(lastLongCyc0 - lastFallCyc0), 32'd10);
`endif
    raw_in = 4'hF; step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- Parametrised, multi-channel successor to the single-button debouncer: CHANNELS independent raw inputs (buttons, switches), each synchronised, filtered and emitted as a clean level plus one-cycle edge pulses.
- Sits between board pins and the processor's manual-clock/step and input-register logic.
- Adds three things: asynchronous reset, an optional prescale tick that stretches the filter window without a wide counter, and per-channel edge strobes.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- THRESH, 500000, consecutive qualifying samples needed before the output flips (>=1).
- CNT_W, 20, stability counter width; must satisfy 2^CNT_W > THRESH.
- RESET_LEVEL, 1, idle/reset level of every channel (idle-high buttons).
- LONG_THRESH, 50000000, held-cycle count for long-press detect (used only with LONG_PRESS_EN).
- LONG_W, 26, long-press counter width; 2^LONG_W > LONG_THRESH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  sample enable; tie to 1 to sample every cycle.
- raw_in  in  CHANNELS  bouncing asynchronous inputs.
- db_level  out  CHANNELS  debounced level.
- db_rise  out  CHANNELS  one-cycle pulse on a debounced 0->1 change.
- db_fall  out  CHANNELS  one-cycle pulse on a debounced 1->0 change.
- long_press  out  CHANNELS  one-cycle pulse on long hold (LONG_PRESS_EN only).

Behaviour:
- Reset (async assert, sync release): both synchroniser stages and db_level = RESET_LEVEL on all bits; all counters = 0; db_rise, db_fall and long_press = 0.
- Synchroniser: two flops per channel (s1, s2). Only s2 feeds the filter.
- Per-channel filter, evaluated every rising clk edge:
  - s2 == db_level: counter cleared to 0, irrespective of tick.
  - s2 != db_level, tick = 0: counter holds.
  - s2 != db_level, tick = 1, counter < THRESH-1: counter +1.
  - s2 != db_level, tick = 1, counter == THRESH-1: db_level <= s2, counter <= 0, and db_rise or db_fall asserted for exactly that next cycle.
- Any single agreeing sample restarts qualification. Glitches shorter than THRESH ticks never reach db_level.
- Latency with tick = 1: a clean raw change sampled by s1 on edge 1 appears on db_level after edge THRESH+2. The pulse is high in the same cycle db_level first shows the new value.
- Pulses are registered, never both high on one channel, and deassert the following cycle.
- The counter never exceeds THRESH-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous flips on several channels are each reported in the same cycle.
- Reset mid-qualification discards the partial count. db_level returns to RESET_LEVEL with no pulse generated.

Optional Feature:
- Macro: MULTI_DEBOUNCER_LONG_PRESS_EN.
- Defined:
  - Each channel has a LONG_W counter, cleared whenever db_level == RESET_LEVEL and incremented every cycle while db_level != RESET_LEVEL (pressed).
  - When the counter reaches LONG_THRESH-1, long_press pulses for one cycle and the counter saturates there.
  - Result: one pulse per press. Releasing re-arms the channel. Reset clears the counter.
- Undefined: no long-press counters are built, and long_press is constant 0. The port is kept so the interface does not change.

Test Plan (CHANNELS=4, THRESH=4, RESET_LEVEL=1, LONG_THRESH=10):
- Reset: assert rst mid-cycle with raw_in=4'b0000 -> db_level=4'b1111 immediately, pulses 0. After release, db_level[0] falls after edge 6, with db_fall[0] high for one cycle.
- Bounce rejection, tick=1: raw_in[1] goes low for 3 cycles, high 1, low 3, high -> db_level[1] stays 1, no pulses. Then hold low for 6 cycles -> exactly one db_fall[1].
- Prescale: tick high 1 cycle in 5, raw_in[2] held low -> db_level[2] falls after the 4th tick sampled at s2 (not earlier). A 1-cycle high blip between ticks resets the count.
- Simultaneous: raw_in[3:2] low together, clean -> db_fall=4'b1100 in one cycle. Release -> db_rise=4'b1100 THRESH+2 edges later.
- Long press, macro defined: hold raw_in[0] low 30 cycles -> long_press[0] pulses once, exactly 10 cycles after db_fall[0]. Release and re-press -> a second single pulse. Macro undefined -> long_press stays 0.
